// File: rtl/count_chk_pkg.sv
// count_chk_pkg: shared types and constants for the 3-bit counter sequence checker.
// State encoding for the tracking FSM, wrap-detection constants, and the modulo-8 successor helper.
// Imported by count_seq_checker and sat_counter.
package count_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [2:0] CNT_MAX_VAL  = 3'd7;
  localparam logic [2:0] CNT_WRAP_VAL = 3'd0;

  // The successor is computed in 3 bits, so 7 wraps to 0 and still counts as good.
  function automatic logic [2:0] next_count(input logic [2:0] v);
    return v + 3'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear.
// Latency: the count updates on the edge that samples inc/clr. clr wins over inc.
// No backpressure; the count holds at all-ones once saturated.
module sat_counter
  import count_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear has priority, then increment unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: tracks a 3-bit up-counter, declares lock after LOCK_CYCLES good steps, counts errors and wraps.
// Latency: outputs are registered on the edge that samples count_in (visible the following cycle).
// No backpressure; samples with count_vld=0 are ignored. Optional sticky_err output under SEQ_CHK_STICKY_EN.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       count_in,
  input  logic             count_vld,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt
`ifdef SEQ_CHK_STICKY_EN
  ,
  output logic             sticky_err
`endif
);

  localparam logic [3:0] LOCK_VAL = 4'(LOCK_CYCLES);

  state_e     state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic [3:0] match_q, match_d;
  logic [3:0] match_inc;
  logic       locked_q;
  logic       err_pulse_q;
  logic       good;
  logic       err_evt;
  logic       wrap_evt;

  assign good      = (count_in == next_count(prev_q));
  assign match_inc = match_q + 4'd1;

  // Next-state logic: everything advances only on valid samples.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    match_d  = match_q;
    err_evt  = 1'b0;
    wrap_evt = 1'b0;
    if (count_vld) begin
      prev_d = count_in;
      case (state_q)
        IDLE: begin
          match_d = 4'd0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (good) begin
            match_d = match_inc;
            if (match_inc == LOCK_VAL) begin
              state_d = LOCKED;
            end
          end else begin
            // A miss while acquiring just restarts the run; it is not an error.
            match_d = 4'd0;
          end
        end
        LOCKED: begin
          if (good) begin
            if ((prev_q == CNT_MAX_VAL) && (count_in == CNT_WRAP_VAL)) begin
              wrap_evt = 1'b1;
            end
          end else begin
            err_evt = 1'b1;
            match_d = 4'd0;
            state_d = ACQUIRE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM, history and registered outputs; reset overrides clear and count_vld.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      prev_q      <= 3'd0;
      match_q     <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      locked_q    <= (state_d == LOCKED);
      err_pulse_q <= err_evt;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (err_evt),
    .cnt     (err_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_wrap_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (wrap_evt),
    .cnt     (wrap_cnt)
  );

`ifdef SEQ_CHK_STICKY_EN
  logic sticky_q;

  // Sticky error flag: an error in the same cycle as clear still sets it, so no event is lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sticky_q <= 1'b0;
    end else if (err_evt) begin
      sticky_q <= 1'b1;
    end else if (clear) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky_err = sticky_q;
`endif

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed vectors with hand-computed expectations for count_seq_checker.
// Driver pushes the expected post-edge outputs into a queue; a monitor pops and compares each cycle.
// Built with CNT_W=2 so saturation of both counters is reachable in a short run.
module tb_count_seq_checker;
  logic       clk;
  logic       reset_n;
  logic [2:0] count_in;
  logic       count_vld;
  logic       clear;
  logic       locked;
  logic       err_pulse;
  logic [1:0] err_cnt;
  logic [1:0] wrap_cnt;
`ifdef SEQ_CHK_STICKY_EN
  logic       sticky_err;
`endif

  count_seq_checker #(.LOCK_CYCLES(4), .CNT_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .count_in  (count_in),
    .count_vld (count_vld),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
`ifdef SEQ_CHK_STICKY_EN
    .wrap_cnt  (wrap_cnt),
    .sticky_err(sticky_err)
`else
    .wrap_cnt  (wrap_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic       lk;
    logic       pl;
    logic [1:0] ec;
    logic [1:0] wc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_idx  = 0;

  // Drive one vector before the next rising edge and record what the outputs must be after it.
  task automatic d(input logic r, input logic v, input logic [2:0] c, input logic cl,
                   input logic el, input logic ep, input logic [1:0] ee, input logic [1:0] ew);
    exp_t e;
    @(negedge clk);
    reset_n   = r;
    count_vld = v;
    count_in  = c;
    clear     = cl;
    e.idx = vec_idx;
    e.lk  = el;
    e.pl  = ep;
    e.ec  = ee;
    e.wc  = ew;
    exp_q.push_back(e);
    vec_idx++;
  endtask

  // Monitor: one expectation per cycle, sampled 1 time unit after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (locked !== e.lk) begin
          failures++;
          $display("FAIL vec%0d locked act=%0b exp=%0b", e.idx, locked, e.lk);
        end
        checks++;
        if (err_pulse !== e.pl) begin
          failures++;
          $display("FAIL vec%0d err_pulse act=%0b exp=%0b", e.idx, err_pulse, e.pl);
        end
        checks++;
        if (err_cnt !== e.ec) begin
          failures++;
          $display("FAIL vec%0d err_cnt act=%0d exp=%0d", e.idx, err_cnt, e.ec);
        end
        checks++;
        if (wrap_cnt !== e.wc) begin
          failures++;
          $display("FAIL vec%0d wrap_cnt act=%0d exp=%0d", e.idx, wrap_cnt, e.wc);
        end
      end
    end
  end

  initial begin
    int budget;
    reset_n   = 1'b0;
    count_vld = 1'b0;
    count_in  = 3'd0;
    clear     = 1'b0;

    // Reset state; reset beats count_vld and clear.
    d(0,0,0,0, 0,0,0,0);
    d(0,1,5,1, 0,0,0,0);

    // Acquire from 0..4: lock on the edge that samples 4.
    d(1,1,0,0, 0,0,0,0);
    d(1,1,1,0, 0,0,0,0);
    d(1,1,2,0, 0,0,0,0);
    d(1,1,3,0, 0,0,0,0);
    d(1,1,4,0, 1,0,0,0);

    // Locked through a 7->0 wrap.
    d(1,1,5,0, 1,0,0,0);
    d(1,1,6,0, 1,0,0,0);
    d(1,1,7,0, 1,0,0,0);
    d(1,1,0,0, 1,0,0,1);
    d(1,1,1,0, 1,0,0,1);

    // Ten idle cycles with a bad value on the bus, then the correct successor of 1.
    for (int i = 0; i < 10; i++) d(1,0,6,0, 1,0,0,1);
    d(1,1,2,0, 1,0,0,1);

    // Error at prev=2 with sample 5, then reacquire on 6,7,0,1 (no wrap counted while acquiring).
    d(1,1,5,0, 0,1,1,1);
    d(1,1,6,0, 0,0,1,1);
    d(1,1,7,0, 0,0,1,1);
    d(1,1,0,0, 0,0,1,1);
    d(1,1,1,0, 1,0,1,1);

    // Second error (repeat of 1), then a miss inside ACQUIRE that is not an error.
    d(1,1,1,0, 0,1,2,1);
    d(1,1,5,0, 0,0,2,1);
    d(1,1,6,0, 0,0,2,1);
    d(1,1,7,0, 0,0,2,1);
    d(1,1,0,0, 0,0,2,1);
    d(1,1,1,0, 1,0,2,1);

    // Third error reaches the 2-bit ceiling.
    d(1,1,3,0, 0,1,3,1);
    d(1,1,4,0, 0,0,3,1);
    d(1,1,5,0, 0,0,3,1);
    d(1,1,6,0, 0,0,3,1);
    d(1,1,7,0, 1,0,3,1);

    // Fourth error: count holds at 3.
    d(1,1,7,0, 0,1,3,1);
    d(1,1,0,0, 0,0,3,1);
    d(1,1,1,0, 0,0,3,1);
    d(1,1,2,0, 0,0,3,1);
    d(1,1,3,0, 1,0,3,1);

    // Three wraps while locked: wrap_cnt goes 2, 3, then holds at 3.
    for (int i = 4; i < 8; i++) d(1,1,3'(i),0, 1,0,3,1);
    d(1,1,0,0, 1,0,3,2);
    for (int i = 1; i < 8; i++) d(1,1,3'(i),0, 1,0,3,2);
    d(1,1,0,0, 1,0,3,3);
    for (int i = 1; i < 8; i++) d(1,1,3'(i),0, 1,0,3,3);
    d(1,1,0,0, 1,0,3,3);

    // Fifth error stays saturated.
    d(1,1,0,0, 0,1,3,3);
    d(1,1,1,0, 0,0,3,3);
    d(1,1,2,0, 0,0,3,3);
    d(1,1,3,0, 0,0,3,3);
    d(1,1,4,0, 1,0,3,3);

    // Sixth error with clear in the same cycle: counters zero, pulse still fires.
    d(1,1,7,1, 0,1,0,0);
    d(1,1,0,0, 0,0,0,0);
    d(1,1,1,0, 0,0,0,0);
    d(1,1,2,0, 0,0,0,0);
    d(1,1,3,0, 1,0,0,0);

    // Build nonzero counters, then reset while locked.
    for (int i = 4; i < 8; i++) d(1,1,3'(i),0, 1,0,0,0);
    d(1,1,0,0, 1,0,0,1);
    d(1,1,3,0, 0,1,1,1);
    d(1,1,4,0, 0,0,1,1);
    d(1,1,5,0, 0,0,1,1);
    d(1,1,6,0, 0,0,1,1);
    d(1,1,7,0, 1,0,1,1);
    d(0,1,0,0, 0,0,0,0);

    // After reset the FSM restarts from IDLE even though 1 follows the old prev.
    d(1,1,1,0, 0,0,0,0);
    d(1,1,2,0, 0,0,0,0);
    d(1,1,3,0, 0,0,0,0);
    d(1,1,4,0, 0,0,0,0);
    d(1,1,5,0, 1,0,0,0);
    d(1,1,6,0, 1,0,0,0);
    d(1,1,7,0, 1,0,0,0);
    d(1,1,0,0, 1,0,0,1);

    // Clear leaves the FSM and lock alone, with and without a valid sample.
    d(1,1,1,1, 1,0,0,0);
    d(1,0,0,1, 1,0,0,0);
    d(1,1,2,0, 1,0,0,0);

    @(negedge clk);
    count_vld = 1'b0;
    clear     = 1'b0;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
